// File: rtl/phys_mem_router_pkg.sv
// rtl/phys_mem_router_pkg.sv - shared types and constants for the physical memory router
package mem_bus_pkg;

    localparam int PADDR_W = 48;
    localparam logic [31:0] BUS_ERR_DATA = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        FAULT,
        HOLD
    } state_t;

    // True when the address fits inside the byte space selected by the device flag
    function automatic logic addr_in_range(input logic [PADDR_W-1:0] addr, input logic dev,
                                           input int ram_bits, input int dev_bits);
        if (dev) begin
            return (addr >> dev_bits) == '0;
        end
        return (addr >> ram_bits) == '0;
    endfunction

endpackage

// File: rtl/phys_mem_router_if.sv
// rtl/phys_mem_router_if.sv - upstream request/response signals between TLB and router
interface phys_mem_router_if;
    import mem_bus_pkg::*;

    logic [PADDR_W-1:0] i_address;
    logic               i_device_space;
    logic               i_mem_read;
    logic               i_mem_write;
    logic               o_mem_valid;
    logic               o_bus_error;

    modport master (
        output i_address, i_device_space, i_mem_read, i_mem_write,
        input  o_mem_valid, o_bus_error
    );

    modport slave (
        input  i_address, i_device_space, i_mem_read, i_mem_write,
        output o_mem_valid, o_bus_error
    );

endinterface

// File: rtl/phys_mem_router_timeout.sv
// rtl/phys_mem_router_timeout.sv - saturating wait-cycle counter that flags a response timeout
module bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    // Raised during the wait cycle that brings the count up to the limit
    assign expired = enable && (count >= LIMIT - 1'b1);

endmodule

// File: rtl/phys_mem_router.sv
// rtl/phys_mem_router.sv - routes TLB physical requests to the RAM or device port with range check and timeout
module phys_mem_router
    import mem_bus_pkg::*;
#(
    parameter int RAM_ADDR_BITS  = 24,
    parameter int DEV_ADDR_BITS  = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    phys_mem_router_if.slave         up,
    inout  wire  [31:0]              io_mem_data,
    output logic                     o_ram_req,
    output logic                     o_ram_we,
    output logic [RAM_ADDR_BITS-1:0] o_ram_addr,
    output logic [31:0]              o_ram_wdata,
    input  logic                     i_ram_ack,
    input  logic [31:0]              i_ram_rdata,
    output logic                     o_dev_req,
    output logic                     o_dev_we,
    output logic [DEV_ADDR_BITS-1:0] o_dev_addr,
    output logic [31:0]              o_dev_wdata,
    input  logic                     i_dev_ack,
    input  logic [31:0]              i_dev_rdata
);
    state_t             state_q, state_d;
    logic [PADDR_W-1:0] addr_q;
    logic               dev_q, rd_q, wr_q;
    logic [31:0]        wdata_q, rdata_q;
    logic               sel_ack, expired, req_active, hold_release;
    logic [31:0]        sel_rdata;
    logic               drive_data;
    logic [31:0]        data_out;

    assign sel_ack   = dev_q ? i_dev_ack : i_ram_ack;
    assign sel_rdata = dev_q ? i_dev_rdata : i_ram_rdata;

    bus_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .clear  (state_q != WAIT),
        .enable (state_q == WAIT),
        .expired(expired)
    );

    // A new access differing from the one just served ends HOLD without rd/wr dropping
    assign hold_release = !(up.i_mem_read || up.i_mem_write) || (up.i_address != addr_q) ||
                          (up.i_mem_read != rd_q) || (up.i_mem_write != wr_q);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            dev_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && (up.i_mem_read || up.i_mem_write)) begin
                addr_q  <= up.i_address;
                dev_q   <= up.i_device_space;
                rd_q    <= up.i_mem_read;
                wr_q    <= up.i_mem_write;
                wdata_q <= io_mem_data;
            end
            if (state_q == WAIT && sel_ack) begin
                rdata_q <= sel_rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (up.i_mem_read || up.i_mem_write) begin
                    if ((up.i_mem_read && up.i_mem_write) ||
                        !addr_in_range(up.i_address, up.i_device_space, RAM_ADDR_BITS, DEV_ADDR_BITS)) begin
                        state_d = FAULT;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (sel_ack) begin
                    state_d = DONE;
                end else if (expired) begin
                    state_d = FAULT;
                end
            end
            DONE, FAULT: state_d = HOLD;
            HOLD: begin
                if (hold_release) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_active = (state_q == ISSUE) || (state_q == WAIT);

    assign o_ram_req   = req_active && !dev_q;
    assign o_ram_we    = o_ram_req && wr_q;
    assign o_ram_addr  = o_ram_req ? addr_q[RAM_ADDR_BITS-1:0] : '0;
    assign o_ram_wdata = o_ram_we ? wdata_q : '0;

    assign o_dev_req   = req_active && dev_q;
    assign o_dev_we    = o_dev_req && wr_q;
    assign o_dev_addr  = o_dev_req ? addr_q[DEV_ADDR_BITS-1:0] : '0;
    assign o_dev_wdata = o_dev_we ? wdata_q : '0;

    assign up.o_mem_valid = (state_q == DONE) || (state_q == FAULT);
    assign up.o_bus_error = (state_q == FAULT);

    assign drive_data  = up.o_mem_valid && rd_q && !wr_q;
    assign data_out    = (state_q == FAULT) ? BUS_ERR_DATA : rdata_q;
    assign io_mem_data = drive_data ? data_out : 'z;

endmodule

// File: tb/tb_phys_mem_router.sv
// tb/tb_phys_mem_router.sv - directed and randomized transactions against a transaction-level model
module tb_phys_mem_router;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ram_ack = 1'b0, dev_ack = 1'b0;
    logic [31:0] ram_rdata = '0, dev_rdata = '0;
    logic        ram_req, ram_we, dev_req, dev_we;
    logic [23:0] ram_addr;
    logic [15:0] dev_addr;
    logic [31:0] ram_wdata, dev_wdata;
    logic        tb_drive = 1'b0;
    logic [31:0] tb_wdata = '0;
    wire  [31:0] mem_data;

    int checks = 0;
    int failures = 0;

    assign mem_data = tb_drive ? tb_wdata : 32'bz;

    phys_mem_router_if bus ();

    phys_mem_router #(
        .RAM_ADDR_BITS (24),
        .DEV_ADDR_BITS (16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .up         (bus),
        .io_mem_data(mem_data),
        .o_ram_req  (ram_req),
        .o_ram_we   (ram_we),
        .o_ram_addr (ram_addr),
        .o_ram_wdata(ram_wdata),
        .i_ram_ack  (ram_ack),
        .i_ram_rdata(ram_rdata),
        .o_dev_req  (dev_req),
        .o_dev_we   (dev_we),
        .o_dev_addr (dev_addr),
        .o_dev_wdata(dev_wdata),
        .i_dev_ack  (dev_ack),
        .i_dev_rdata(dev_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction: the model predicts fault/timeout, request length, response data.
    // lat = WAIT cycles the responder lets pass before acking; skew = idle cycles before issue.
    task automatic run_txn(input string tag, input logic [47:0] addr, input logic dev,
                           input logic rd, input logic wr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int lat, input bit drop, input int skew);
        bit          illegal, tmo, seen, sreq, ack;
        int          exp_req, req_cnt, bad_other, bad_field, vidx, extra;
        logic        err_obs;
        logic [31:0] data_obs;
        illegal = (rd && wr) || (dev ? (addr >= 48'h1_0000) : (addr >= 48'h100_0000));
        tmo     = !illegal && (lat >= TO);
        exp_req = illegal ? 0 : (tmo ? TO + 1 : lat + 2);
        req_cnt = 0; bad_other = 0; bad_field = 0; vidx = -1; extra = 0;
        err_obs = 1'b0; data_obs = '0; seen = 1'b0;
        bus.i_address = addr; bus.i_device_space = dev;
        bus.i_mem_read = rd; bus.i_mem_write = wr;
        tb_drive = wr; tb_wdata = wdata;
        ram_rdata = dev ? ~rdata : rdata;
        dev_rdata = dev ? rdata : ~rdata;
        for (int cyc = 0; cyc < 60 && !seen; cyc++) begin
            @(negedge clk);
            sreq = dev ? dev_req : ram_req;
            if (dev ? (ram_req || ram_we || ram_addr != 0 || ram_wdata != 0)
                    : (dev_req || dev_we || dev_addr != 0 || dev_wdata != 0)) bad_other++;
            if (sreq) begin
                req_cnt++;
                if (dev ? (dev_addr !== addr[15:0] || dev_we !== wr || dev_wdata !== (wr ? wdata : 32'h0))
                        : (ram_addr !== addr[23:0] || ram_we !== wr || ram_wdata !== (wr ? wdata : 32'h0)))
                    bad_field++;
            end
            if (bus.o_mem_valid) begin
                seen = 1'b1; vidx = cyc; err_obs = bus.o_bus_error; data_obs = mem_data;
            end
            ack = sreq && !tmo && (req_cnt == lat + 2);
            ram_ack = ack && !dev;
            dev_ack = ack && dev;
        end
        check({tag, ".valid_seen"}, seen, 1'b1);
        check({tag, ".valid_cycle"}, vidx, exp_req + skew);
        check({tag, ".req_cycles"}, req_cnt, exp_req);
        check({tag, ".bus_error"}, err_obs, illegal || tmo);
        check({tag, ".other_port_idle"}, bad_other, 0);
        check({tag, ".req_fields"}, bad_field, 0);
        if (rd && !wr) check({tag, ".rdata"}, data_obs, (illegal || tmo) ? 32'hFFFF_FFFF : rdata);
        if (drop) begin
            bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b0; tb_drive = 1'b0;
            for (int c = 0; c < 3; c++) begin
                ram_ack = (c == 0); dev_ack = (c == 0);
                @(negedge clk);
                if (bus.o_mem_valid || ram_req || dev_req) extra++;
            end
            ram_ack = 1'b0; dev_ack = 1'b0;
            check({tag, ".quiet_after"}, extra, 0);
        end
    endtask

    initial begin
        bus.i_address = '0; bus.i_device_space = 1'b0;
        bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b0;
        #12;
        check("reset.valid", bus.o_mem_valid, 1'b0);
        check("reset.error", bus.o_bus_error, 1'b0);
        check("reset.ram_req", ram_req, 1'b0);
        check("reset.dev_req", dev_req, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_txn("ram_read", 48'h0000_0012_3400, 1'b0, 1'b1, 1'b0, 32'h0, 32'hDEAD_BEEF, 1, 1'b1, 0);
        run_txn("dev_write", 48'h0040, 1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 32'h0, 0, 1'b1, 0);
        run_txn("ram_range", 48'h0000_0100_0000, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1234_5678, 0, 1'b1, 0);
        run_txn("dev_timeout", 48'h0080, 1'b1, 1'b1, 1'b0, 32'h0, 32'h5555_AAAA, 99, 1'b1, 0);
        run_txn("rd_and_wr", 48'h0010, 1'b0, 1'b1, 1'b1, 32'hCAFE_0000, 32'h0, 0, 1'b1, 0);
        run_txn("walk", 48'h2000, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_3001, 0, 1'b0, 0);
        run_txn("walk_data", 48'h3004, 1'b0, 1'b1, 1'b0, 32'h0, 32'h7777_0002, 0, 1'b1, 2);
        run_txn("ack_at_limit", 48'h00FF_FFFC, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0BAD_F00D, TO - 1, 1'b1, 0);
        run_txn("dev_range", 48'h1_0000, 1'b1, 1'b0, 1'b1, 32'h1111_2222, 32'h0, 0, 1'b1, 0);

        bus.i_address = 48'h0000_0000_0100; bus.i_device_space = 1'b0;
        bus.i_mem_read = 1'b1; bus.i_mem_write = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid.req_before", ram_req, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid.ram_req", ram_req, 1'b0);
        check("rst_mid.ram_addr", ram_addr, 24'h0);
        check("rst_mid.valid", bus.o_mem_valid, 1'b0);
        @(negedge clk);
        bus.i_mem_read = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        run_txn("after_rst", 48'h0000_0000_0100, 1'b0, 1'b1, 1'b0, 32'h0, 32'h600D_0001, 2, 1'b1, 0);

        for (int i = 0; i < 24; i++) begin
            logic [47:0] a;
            logic        d, r, w;
            int          k;
            d = 1'($urandom_range(0, 1));
            a = d ? 48'($urandom_range(0, 32'hFFFF)) : 48'($urandom_range(0, 32'hFF_FFFF));
            if ($urandom_range(0, 3) == 0) a = a | (48'h1 << $urandom_range(d ? 16 : 24, 47));
            k = $urandom_range(0, 9);
            r = (k == 0) || (k % 2 == 1);
            w = (k == 0) || (k % 2 == 0);
            run_txn($sformatf("rand%0d", i), a, d, r, w, $urandom, $urandom,
                    $urandom_range(0, 5), 1'b1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
